// File: rtl/periph_write_post_buf_pkg.sv
// Shared definitions for the peripheral posted-write buffer.
// Optional build macro: WPB_RAW_FWD_EN (read-after-write forwarding from queued entries).
package periph_write_post_buf_pkg;

    // Memory-bus defaults
    localparam int unsigned WPB_ADDR_W_DEFAULT = 32;
    localparam int unsigned WPB_DATA_W_DEFAULT = 32;
    localparam int unsigned WPB_DEPTH_DEFAULT  = 4;

    // Drain FSM encoding
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_WR    = 2'd1,
        D_RD    = 2'd2,
        D_RDONE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/wpb_fifo.sv
// Synchronous FIFO with push/pop/head/full/empty/count.
// With WPB_RAW_FWD_EN defined, the storage array and head pointer are exported for lookups.
module wpb_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [W-1:0]                din,
    input  logic                        pop,
    output logic [W-1:0]                head,
    output logic                        full,
    output logic                        empty,
`ifdef WPB_RAW_FWD_EN
    output logic [DEPTH-1:0][W-1:0]     entries,
    output logic [PTR_W-1:0]            head_ptr,
`endif
    output logic [CNT_W-1:0]            count
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;

    // Storage write; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == CNT_W'(0));

`ifdef WPB_RAW_FWD_EN
    assign entries  = mem;
    assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/periph_write_post_buf.sv
// Posted-write buffer between the memory controller peripheral port and the AXI master.
// Writes are acknowledged on entry to the FIFO; reads stay ordered behind all posted writes.
// Optional build macro: WPB_RAW_FWD_EN answers reads from the youngest matching queued write.
module periph_write_post_buf
    import periph_write_post_buf_pkg::*;
#(
    parameter int unsigned ADDR_W = WPB_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = WPB_DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = WPB_DEPTH_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] P_AXIAddr,
    input  logic              P_StartAXIWrite,
    input  logic              P_StartAXIRead,
    input  logic [DATA_W-1:0] P_WriteData,
    output logic [DATA_W-1:0] P_ReadData,
    output logic              P_WriteCompleted,
    output logic              P_ReadCompleted,
    output logic [ADDR_W-1:0] M_AXIAddr,
    output logic              M_StartAXIWrite,
    output logic              M_StartAXIRead,
    output logic [DATA_W-1:0] M_WriteData,
    input  logic [DATA_W-1:0] M_ReadData,
    input  logic              M_WriteCompleted,
    input  logic              M_ReadCompleted,
    output logic              Empty
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    drain_state_t       state;
    logic               pend_valid;
    logic               pend_is_read;
    logic [ADDR_W-1:0]  pend_addr;
    logic [DATA_W-1:0]  pend_data;
    logic               push;
    logic               pop;
    logic               fwd_hit;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Posting is gated only by registered state, so the ack is a clean decode
    assign push             = pend_valid & ~pend_is_read & ~fifo_full;
    assign pop              = (state == D_WR) & M_WriteCompleted;
    assign P_WriteCompleted = push;
    assign Empty            = (fifo_count == CNT_W'(0)) & (state == D_IDLE) & ~pend_valid;

`ifdef WPB_RAW_FWD_EN
    logic [DEPTH-1:0][ENTRY_W-1:0] fifo_entries;
    logic [PTR_W-1:0]              fifo_head_ptr;
    logic [PTR_W-1:0]              fwd_idx;
    logic [DATA_W-1:0]             fwd_data;

    wpb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (Clk),
        .rst_n    (Rst),
        .push     (push),
        .din      ({pend_addr, pend_data}),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .entries  (fifo_entries),
        .head_ptr (fifo_head_ptr),
        .count    (fifo_count)
    );

    // Scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = fifo_head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < fifo_count) &&
                (fifo_entries[fwd_idx][ENTRY_W-1 -: ADDR_W] == pend_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_entries[fwd_idx][DATA_W-1:0];
            end
        end
        if (!(pend_valid && pend_is_read)) fwd_hit = 1'b0;
    end
`else
    wpb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (Clk),
        .rst_n (Rst),
        .push  (push),
        .din   ({pend_addr, pend_data}),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fwd_hit = 1'b0;
`endif

    // Single-entry pending slot; new requests are dropped while it is occupied
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pend_valid   <= 1'b0;
            pend_is_read <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
        end else if (pend_valid) begin
            if (push || fwd_hit || (state == D_RDONE)) pend_valid <= 1'b0;
        end else if (P_StartAXIWrite || P_StartAXIRead) begin
            pend_valid   <= 1'b1;
            pend_is_read <= ~P_StartAXIWrite;
            pend_addr    <= P_AXIAddr;
            pend_data    <= P_WriteData;
        end
    end

    // Drain FSM: one AXI transaction at a time, reads only once all writes have retired
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state           <= D_IDLE;
            M_AXIAddr       <= '0;
            M_WriteData     <= '0;
            M_StartAXIWrite <= 1'b0;
            M_StartAXIRead  <= 1'b0;
            P_ReadData      <= '0;
            P_ReadCompleted <= 1'b0;
        end else begin
            M_StartAXIWrite <= 1'b0;
            M_StartAXIRead  <= 1'b0;
            P_ReadCompleted <= fwd_hit;
`ifdef WPB_RAW_FWD_EN
            if (fwd_hit) P_ReadData <= fwd_data;
`endif
            case (state)
                D_IDLE: begin
                    if (!fifo_empty) begin
                        M_AXIAddr       <= fifo_head[ENTRY_W-1 -: ADDR_W];
                        M_WriteData     <= fifo_head[DATA_W-1:0];
                        M_StartAXIWrite <= 1'b1;
                        state           <= D_WR;
                    end else if (pend_valid && pend_is_read) begin
                        M_AXIAddr      <= pend_addr;
                        M_StartAXIRead <= 1'b1;
                        state          <= D_RD;
                    end
                end
                D_WR: begin
                    if (M_WriteCompleted) state <= D_IDLE;
                end
                D_RD: begin
                    if (M_ReadCompleted) begin
                        P_ReadData      <= M_ReadData;
                        P_ReadCompleted <= 1'b1;
                        state           <= D_RDONE;
                    end
                end
                D_RDONE: begin
                    state <= D_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Upstream protocol checks: one request at a time, never both kinds at once
    always_ff @(posedge Clk) begin
        if (Rst) begin
            assert (!(P_StartAXIWrite && P_StartAXIRead));
            assert (!(pend_valid && (P_StartAXIWrite || P_StartAXIRead)));
        end
    end
`endif

endmodule

// File: tb/tb_periph_write_post_buf.sv
// Directed bench for periph_write_post_buf: table of single writes plus hand sequences
// for full-FIFO stall, read ordering / forwarding, mid-transaction reset and pointer wrap.
module tb_periph_write_post_buf;

    logic        Clk;
    logic        Rst;
    logic [31:0] P_AXIAddr;
    logic        P_StartAXIWrite;
    logic        P_StartAXIRead;
    logic [31:0] P_WriteData;
    logic [31:0] P_ReadData;
    logic        P_WriteCompleted;
    logic        P_ReadCompleted;
    logic [31:0] M_AXIAddr;
    logic        M_StartAXIWrite;
    logic        M_StartAXIRead;
    logic [31:0] M_WriteData;
    logic [31:0] M_ReadData;
    logic        M_WriteCompleted;
    logic        M_ReadCompleted;
    logic        Empty;

    periph_write_post_buf dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .P_AXIAddr        (P_AXIAddr),
        .P_StartAXIWrite  (P_StartAXIWrite),
        .P_StartAXIRead   (P_StartAXIRead),
        .P_WriteData      (P_WriteData),
        .P_ReadData       (P_ReadData),
        .P_WriteCompleted (P_WriteCompleted),
        .P_ReadCompleted  (P_ReadCompleted),
        .M_AXIAddr        (M_AXIAddr),
        .M_StartAXIWrite  (M_StartAXIWrite),
        .M_StartAXIRead   (M_StartAXIRead),
        .M_WriteData      (M_WriteData),
        .M_ReadData       (M_ReadData),
        .M_WriteCompleted (M_WriteCompleted),
        .M_ReadCompleted  (M_ReadCompleted),
        .Empty            (Empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Free-running cycle count and independent start-pulse monitors
    int cyc = 0;
    int wr_starts = 0;
    int rd_starts = 0;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) begin
        if (M_StartAXIWrite) wr_starts <= wr_starts + 1;
        if (M_StartAXIRead)  rd_starts <= rd_starts + 1;
    end

    // AXI slave model
    int          wr_delay    = 3;
    int          rd_delay    = 3;
    logic [31:0] rd_data_cfg = 32'h1234_5678;
    int          rst_epoch   = 0;
    int          wr_resp_cnt = 0;
    int          wr_done_cycle = 0;
    int          rd_start_cycle = 0;
    logic [63:0] obs_q[$];

    initial begin
        int ep;
        M_WriteCompleted = 1'b0;
        M_ReadCompleted  = 1'b0;
        M_ReadData       = '0;
        forever begin
            @(negedge Clk);
            if (M_StartAXIWrite) begin
                obs_q.push_back({M_AXIAddr, M_WriteData});
                ep = rst_epoch;
                repeat (wr_delay) @(posedge Clk);
                #1;
                if (ep == rst_epoch) begin
                    M_WriteCompleted = 1'b1;
                    wr_resp_cnt++;
                    wr_done_cycle = cyc;
                    @(posedge Clk);
                    #1;
                    M_WriteCompleted = 1'b0;
                end
            end else if (M_StartAXIRead) begin
                rd_start_cycle = cyc;
                repeat (rd_delay) @(posedge Clk);
                #1;
                M_ReadData      = rd_data_cfg;
                M_ReadCompleted = 1'b1;
                @(posedge Clk);
                #1;
                M_ReadCompleted = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue a write; lat counts cycles from the start pulse to the ack (1 when not full)
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        @(posedge Clk); #1;
        P_AXIAddr       = a;
        P_WriteData     = d;
        P_StartAXIWrite = 1'b1;
        @(posedge Clk); #1;
        P_StartAXIWrite = 1'b0;
        lat = 1;
        @(negedge Clk);
        while (!P_WriteCompleted && lat < 200) begin
            lat++;
            @(negedge Clk);
        end
        if (!P_WriteCompleted) check("wr_ack_timeout", {63'd0, P_WriteCompleted}, 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d);
        @(posedge Clk); #1;
        P_AXIAddr      = a;
        P_StartAXIRead = 1'b1;
        @(posedge Clk); #1;
        P_StartAXIRead = 1'b0;
        lat = 1;
        @(negedge Clk);
        while (!P_ReadCompleted && lat < 300) begin
            lat++;
            @(negedge Clk);
        end
        if (!P_ReadCompleted) check("rd_done_timeout", {63'd0, P_ReadCompleted}, 64'd1);
        d = P_ReadData;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        @(negedge Clk);
        while (!Empty && n < 400) begin
            n++;
            @(negedge Clk);
        end
        check(name, {63'd0, Empty}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_data"}, {M_AXIAddr, M_WriteData}, 64'd0);
        check({tag, "_ctrl"}, {28'd0, P_ReadData, P_WriteCompleted, P_ReadCompleted,
                               M_StartAXIWrite, M_StartAXIRead}, 64'd0);
        check({tag, "_empty"}, {63'd0, Empty}, 64'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
        int          exp_lat;
    } wr_vec_t;

    wr_vec_t     vecs[4];
    logic [63:0] exp_q[$];
    logic [63:0] got;
    logic [31:0] rdat;
    int          lat;
    int          starts_snap;
    int          resp_snap;
    int          rd_snap;

    initial begin
        vecs[0] = '{32'h4000_0010, 32'hDEAD_BEEF, 3, 1};
        vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 1, 1};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 7, 1};
        vecs[3] = '{32'h4000_0100, 32'hA5A5_5A5A, 2, 1};

        Rst = 1'b0;
        P_AXIAddr = '0;
        P_WriteData = '0;
        P_StartAXIWrite = 1'b0;
        P_StartAXIRead = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Rst = 1'b1;

        // Isolated single writes
        for (int i = 0; i < 4; i++) begin
            obs_q.delete();
            wr_delay = vecs[i].delay;
            do_write(vecs[i].addr, vecs[i].data, lat);
            check($sformatf("single%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("single%0d_busy", i), {63'd0, Empty}, 64'd0);
            wait_empty($sformatf("single%0d_empty", i));
            check($sformatf("single%0d_issued", i), 64'(obs_q.size()), 64'd1);
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                check($sformatf("single%0d_axi", i), got, {vecs[i].addr, vecs[i].data});
            end
        end

        // Five back-to-back writes against a slow slave: the fifth stalls until the first pop
        obs_q.delete();
        exp_q.delete();
        wr_delay = 20;
        resp_snap = wr_resp_cnt;
        for (int i = 0; i < 5; i++) begin
            do_write(32'h4000_0200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), lat);
            exp_q.push_back({32'h4000_0200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i)});
            if (i < 4) check($sformatf("b2b%0d_lat", i), 64'(lat), 64'd1);
            check($sformatf("b2b%0d_resp_before_ack", i), 64'(wr_resp_cnt - resp_snap),
                  (i < 4) ? 64'd0 : 64'd1);
        end
        wait_empty("b2b_empty");
        check("b2b_issued", 64'(obs_q.size()), 64'd5);
        for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            check($sformatf("b2b%0d_order", i), got, exp_q[i]);
        end

        // Write A then read A
        obs_q.delete();
        wr_delay = 10;
        rd_delay = 3;
        rd_data_cfg = 32'h1234_5678;
        rd_snap = rd_starts;
        do_write(32'h4000_0300, 32'hFACE_CAFE, lat);
        do_read(32'h4000_0300, lat, rdat);
`ifdef WPB_RAW_FWD_EN
        check("raw_fwd_lat", 64'(lat), 64'd2);
        check("raw_fwd_data", {32'd0, rdat}, {32'd0, 32'hFACE_CAFE});
        wait_empty("raw_empty");
        check("raw_no_axi_read", 64'(rd_starts - rd_snap), 64'd0);
        repeat (4) @(negedge Clk);
        check("raw_data_hold", {32'd0, P_ReadData}, {32'd0, 32'hFACE_CAFE});
`else
        check("raw_data", {32'd0, rdat}, {32'd0, 32'h1234_5678});
        check("raw_axi_reads", 64'(rd_starts - rd_snap), 64'd1);
        check("raw_read_after_wr", {63'd0, rd_start_cycle > wr_done_cycle}, 64'd1);
        wait_empty("raw_empty");
        repeat (4) @(negedge Clk);
        check("raw_data_hold", {32'd0, P_ReadData}, {32'd0, 32'h1234_5678});
`endif

        // Reset while in D_WR with three entries queued
        obs_q.delete();
        wr_delay = 50;
        for (int i = 0; i < 3; i++) begin
            do_write(32'h4000_0400 + 32'(i * 4), 32'h5EED_0000 + 32'(i), lat);
        end
        repeat (2) @(negedge Clk);
        check("midrst_busy", {63'd0, Empty}, 64'd0);
        starts_snap = wr_starts;
        @(posedge Clk); #2;
        rst_epoch++;
        Rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge Clk);
        Rst = 1'b1;
        repeat (80) @(negedge Clk);
        check("midrst_no_starts", 64'(wr_starts - starts_snap), 64'd0);
        check("midrst_idle_empty", {63'd0, Empty}, 64'd1);

        // Ten writes in a row exercise pointer wrap-around
        obs_q.delete();
        exp_q.delete();
        wr_delay = 2;
        for (int i = 0; i < 10; i++) begin
            do_write(32'h4000_1000 + 32'(i * 16), 32'h0BAD_F000 ^ 32'(i * 32'h0101_0101), lat);
            exp_q.push_back({32'h4000_1000 + 32'(i * 16), 32'h0BAD_F000 ^ 32'(i * 32'h0101_0101)});
        end
        wait_empty("wrap_empty");
        check("wrap_issued", 64'(obs_q.size()), 64'd10);
        for (int i = 0; i < 10 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            check($sformatf("wrap%0d_order", i), got, exp_q[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
